alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit aluControl code from the ALU control decoder, together with two operands and a shift amount.
- Produces a registered result and a zero flag.
- Logical/arithmetic ops complete in one cycle. SRL runs iteratively, one bit per cycle, with a start/busy/done handshake so the datapath can stall on shifts.

---
 rtl/alu_exec_unit.sv | 130 +++++++++++++
 tb/tb_alu_exec_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU. Logical/arithmetic ops finish in a single cycle; SRL is
// iterative (one bit per cycle) so the datapath can stall on shifts.
//
// Ports:
//   clk        : system clock, all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   start      : request pulse, sampled only while not busy
//   aluControl : 4-bit op code from the ALU control decoder, sampled with start
//   srcA       : operand A, sampled with start
//   srcB       : operand B (also the value shifted by SRL), sampled with start
//   shamt      : SRL shift amount, sampled with start
//   aluResult  : registered result, held until the next completion
//   zero       : registered, 1 when aluResult == 0
//   busy       : high while an SRL iteration is in progress
//   done       : one-cycle completion pulse
// ----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         aluControl,
    input  logic [WIDTH-1:0]   srcA,
    input  logic [WIDTH-1:0]   srcB,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   aluResult,
    output logic               zero,
    output logic               busy,
    output logic               done
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   shreg_next;
    logic [WIDTH-1:0]   single_res;
    logic               srl_iter;

    // Single-cycle result. The SRL arm is only used when shamt == 0, where
    // the shifted value is srcB unchanged; unknown codes fall back to ADD.
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       ctrl,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH-1:0]        r;
        sa = a;
        sb = b;
        case (ctrl)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SRL:  r = b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    assign shreg_next = {1'b0, shreg[WIDTH-1:1]};
    assign single_res = alu_single(aluControl, srcA, srcB);
    assign srl_iter   = (aluControl == OP_SRL) && (shamt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            aluResult <= '0;
            zero      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (srl_iter) begin
                            shreg <= srcB;
                            cnt   <= shamt;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end else begin
                            aluResult <= single_res;
                            zero      <= (single_res == '0);
                            done      <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // start is deliberately not looked at here: requests
                    // arriving mid-shift are dropped, not queued.
                    shreg <= shreg_next;
                    cnt   <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        aluResult <= shreg_next;
                        zero      <= (shreg_next == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
// Scoreboard bench: the driver pushes the expected result and completion
// cycle for every accepted request; a monitor on the falling edge pops on
// done and also tracks the expected held result and busy window each cycle.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SRL  = 4'b1001;
    localparam logic [3:0] C_SLTU = 4'b1111;

    logic               clk;
    logic               reset;
    logic               start;
    logic [3:0]         aluControl;
    logic [WIDTH-1:0]   srcA;
    logic [WIDTH-1:0]   srcB;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   aluResult;
    logic               zero;
    logic               busy;
    logic               done;

    alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .aluControl (aluControl),
        .srcA       (srcA),
        .srcB       (srcB),
        .shamt      (shamt),
        .aluResult  (aluResult),
        .zero       (zero),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: value N is visible during the cycle following the Nth edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               busy_from;
        int               due;
    } exp_t;

    exp_t             q[$];
    exp_t             mon_e;
    logic [WIDTH-1:0] held = '0;
    logic             mon_en = 1'b0;
    logic             exp_busy;
    int               checks = 0;
    int               errors = 0;

    // Reference model: straight from the op-code table.
    function automatic logic [WIDTH-1:0] model(input logic [3:0] c,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [SHAMT_W-1:0] s);
        case (c)
            C_ADD:   return a + b;
            C_SUB:   return a - b;
            C_AND:   return a & b;
            C_OR:    return a | b;
            C_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            C_SRL:   return b >> s;
            default: return a + b;
        endcase
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            exp_busy = 1'b0;
            foreach (q[i])
                if (cyc >= q[i].busy_from && cyc < q[i].due) exp_busy = 1'b1;
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
            end
            if (done === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d got done=1 exp done=0", cyc);
                end else begin
                    mon_e = q.pop_front();
                    held  = mon_e.res;
                    if (cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL done_cycle got=%0d exp=%0d", cyc, mon_e.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                checks++;
                errors++;
                mon_e = q.pop_front();
                held  = mon_e.res;
                $display("FAIL missing_done cyc=%0d got done=%b exp done=1", cyc, done);
            end
            checks++;
            if (aluResult !== held) begin
                errors++;
                $display("FAIL result cyc=%0d got=%h exp=%h", cyc, aluResult, held);
            end
            checks++;
            if (zero !== (held == '0)) begin
                errors++;
                $display("FAIL zero cyc=%0d got=%b exp=%b", cyc, zero, (held == '0));
            end
        end
        // Reset takes effect at the next edge: drop everything in flight.
        if (reset === 1'b1) begin
            q.delete();
            held = '0;
        end
    end

    task automatic scramble();
        srcA       = $urandom;
        srcB       = $urandom;
        shamt      = SHAMT_W'($urandom);
        aluControl = 4'($urandom);
    endtask

    task automatic issue(input logic [3:0] c, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [SHAMT_W-1:0] s);
        exp_t e;
        aluControl  = c;
        srcA        = a;
        srcB        = b;
        shamt       = s;
        start       = 1'b1;
        e.res       = model(c, a, b, s);
        e.busy_from = cyc + 1;
        e.due       = cyc + 1 + ((c == C_SRL && s != 0) ? int'(s) : 0);
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
    endtask

    // Request presented while busy: must be dropped, so nothing is expected.
    task automatic poke();
        aluControl = C_ADD;
        srcA       = $urandom;
        srcB       = $urandom;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && busy === 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (busy !== 1'b0) begin
            $display("FAIL wait_idle got busy=%b exp busy=0 within 64 cycles", busy);
            $fatal(1);
        end
    endtask

    logic [3:0] codes [10];
    logic [3:0]         rc;
    logic [SHAMT_W-1:0] rs;
    logic [WIDTH-1:0]   ra;
    logic [WIDTH-1:0]   rb;

    initial begin
        codes = '{C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_SLTU, C_SRL, C_SRL, 4'b0101, 4'b1100};
        reset = 1'b1;
        start = 1'b0;
        aluControl = '0;
        srcA  = '0;
        srcB  = '0;
        shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(5);

        // Single-cycle ops, including back-to-back pairs
        issue(C_ADD, 32'h7FFF_FFFF, 32'h1, 0);
        idle(1);
        issue(C_SUB, 32'd5, 32'd5, 0);
        idle(1);
        issue(C_AND, 32'hF0F0, 32'hFF00, 0);
        issue(C_OR,  32'hF0F0, 32'hFF00, 0);
        idle(1);
        issue(C_SLT,  32'hFFFF_FFFF, 32'd1, 0);
        issue(C_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
        issue(4'b0101, 32'd3, 32'd4, 0);
        idle(2);

        // SRL with a dropped request mid-shift, then shamt=0
        issue(C_SRL, 32'h0, 32'h8000_0000, 5'd4);
        poke();
        wait_idle();
        idle(1);
        issue(C_SRL, 32'h0, 32'h8000_0000, 5'd0);
        idle(2);

        // Longest shift, then abort one on its 3rd busy cycle
        issue(C_SRL, 32'h0, 32'hFFFF_FFFF, 5'd31);
        wait_idle();
        idle(1);
        issue(C_SRL, 32'h0, 32'hFFFF_FFFF, 5'd31);
        idle(2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(4);

        // Back-to-back ADDs, the first issued in an SRL's done cycle
        issue(C_SRL, 32'h0, 32'h1234_5678, 5'd2);
        wait_idle();
        issue(C_ADD, 32'd10, 32'd20, 0);
        issue(C_ADD, 32'hFFFF_FFFF, 32'd1, 0);
        issue(C_ADD, 32'd1, 32'd2, 0);
        idle(2);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            rc = codes[$urandom_range(0, 9)];
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? ra : 32'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? SHAMT_W'($urandom_range(0, 31))
                                             : SHAMT_W'($urandom_range(0, 3));
            issue(rc, ra, rb, rs);
            if (busy === 1'b1 && $urandom_range(0, 1) == 1) poke();
            wait_idle();
            if ($urandom_range(0, 1) == 1) idle(1);
        end

        // Drain
        for (int i = 0; i < 100 && q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        if (q.size() > 0) begin
            $display("FAIL drain got pending=%0d exp pending=0", q.size());
            $fatal(1);
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
